// File: rtl/menu_pkg.sv
// Shared definitions for the menu navigator: FSM states, default menu layout
// and row identifiers.
package menu_pkg;

  typedef enum logic [1:0] {INICIO, PASO, SOSTENIDO, REPITE} estado_t;

  localparam int unsigned FILA_NUEVO   = 1;
  localparam int unsigned FILA_GUARDAR = 2;
  localparam int unsigned FILA_CERRAR  = 3;
  localparam int unsigned FILA_MAYUS   = 4;
  localparam int unsigned FILA_COLOR   = 5;
  localparam int unsigned FILA_ESCALA  = 6;

  // Fields packed row6..row1, 3 bits each
  localparam logic [17:0] COLS_POR_FILA_DEF = {3'd3, 3'd6, 3'd2, 3'd1, 3'd1, 3'd1};
  localparam logic [5:0]  ES_ACCION_DEF     = 6'b000111;
  localparam logic [17:0] SEL_RESET_DEF     = {3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};

endpackage

// File: rtl/repetidor_boton.sv
// Registers one button, detects its rising edge and generates hold/auto-repeat
// step strobes while it stays pressed.
module repetidor_boton
  import menu_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 15_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic boton,
  input  logic reinicio,
  output logic flanco,
  output logic paso
);

  localparam int unsigned MAX_CICLOS = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CICLOS + 1);
  localparam logic [CNT_W-1:0] FIN_HOLD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] FIN_REP  = CNT_W'(REPEAT_CYCLES - 1);

  logic             boton_q;
  logic             boton_prev;
  estado_t          estado;
  logic [CNT_W-1:0] cnt;
  logic             tick;

  assign flanco = boton_q & ~boton_prev;

  always_comb begin
    tick = 1'b0;
    if (boton_q) begin
      case (estado)
        SOSTENIDO: tick = (cnt == FIN_HOLD);
        REPITE:    tick = (cnt == FIN_REP);
        default:   tick = 1'b0;
      endcase
    end
  end

  // Another button's edge restarts this one, so its pending repeat is dropped.
  assign paso = flanco | (tick & ~reinicio);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      boton_q    <= 1'b0;
      boton_prev <= 1'b0;
      estado     <= INICIO;
      cnt        <= '0;
    end else begin
      boton_q    <= boton;
      boton_prev <= boton_q;
      if (!boton_q) begin
        estado <= INICIO;
        cnt    <= '0;
      end else if (flanco || reinicio) begin
        estado <= PASO;
        cnt    <= '0;
      end else begin
        case (estado)
          PASO: begin
            estado <= SOSTENIDO;
            cnt    <= '0;
          end
          SOSTENIDO: begin
            if (tick) begin
              estado <= REPITE;
              cnt    <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          REPITE: begin
            if (tick) cnt <= '0;
            else      cnt <= cnt + 1'b1;
          end
          default: begin
            estado <= INICIO;
            cnt    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/menu_navegador_param.sv
// Menu navigator: row/column cursor driven by five buttons with auto-repeat,
// per-row committed selections and strobes for action rows.
module menu_navegador_param
  import menu_pkg::*;
#(
  parameter int unsigned NUM_FILAS     = 6,
  parameter int unsigned MAX_COLS      = 6,
  parameter int unsigned IDX_W         = 3,
  parameter logic [NUM_FILAS*IDX_W-1:0] COLS_POR_FILA = COLS_POR_FILA_DEF,
  parameter logic [NUM_FILAS-1:0]       ES_ACCION     = ES_ACCION_DEF,
  parameter logic [NUM_FILAS*IDX_W-1:0] SEL_RESET     = SEL_RESET_DEF,
  parameter bit          WRAP          = 1'b0,
  parameter int unsigned HOLD_CYCLES   = 50_000_000,
  parameter int unsigned REPEAT_CYCLES = 15_000_000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       boton_arriba,
  input  logic                       boton_abajo,
  input  logic                       boton_izq,
  input  logic                       boton_der,
  input  logic                       boton_elige,
  output logic [IDX_W-1:0]           where_fila,
  output logic [IDX_W-1:0]           where_columna,
  output logic [NUM_FILAS*IDX_W-1:0] sel_vec,
  output logic [NUM_FILAS*IDX_W-1:0] sel_temp,
  output logic [NUM_FILAS-1:0]       accion_pulso
);

  function automatic logic [NUM_FILAS*IDX_W-1:0] sel_inicial();
    logic [NUM_FILAS*IDX_W-1:0] v;
    v = SEL_RESET;
    for (int unsigned r = 0; r < NUM_FILAS; r++)
      if (ES_ACCION[r]) v[r*IDX_W +: IDX_W] = IDX_W'(1);
    return v;
  endfunction

  localparam logic [NUM_FILAS*IDX_W-1:0] SEL_INICIAL = sel_inicial();
  localparam logic [IDX_W-1:0] UNO = IDX_W'(1);

  // Index 0 arriba, 1 abajo, 2 izq, 3 der, 4 elige
  logic [3:0]       boton_dir;
  logic [4:0]       flancos;
  logic [3:0]       reinicio_dir;
  logic [3:0]       paso_dir;
  logic             elige_q;
  logic             elige_prev;
  logic [IDX_W-1:0] limite;

  assign boton_dir  = {boton_der, boton_izq, boton_abajo, boton_arriba};
  assign flancos[4] = elige_q & ~elige_prev;

  always_comb begin
    reinicio_dir = '0;
    for (int unsigned i = 0; i < 4; i++)
      reinicio_dir[i] = |(flancos & ~(5'b00001 << i));
  end

  for (genvar i = 0; i < 4; i++) begin : g_rep
    repetidor_boton #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_rep (
      .clk     (clk),
      .reset   (reset),
      .boton   (boton_dir[i]),
      .reinicio(reinicio_dir[i]),
      .flanco  (flancos[i]),
      .paso    (paso_dir[i])
    );
  end

  always_comb begin
    limite = UNO;
    for (int unsigned r = 0; r < NUM_FILAS; r++) begin
      if (where_fila == IDX_W'(r + 1)) begin
        limite = (COLS_POR_FILA[r*IDX_W +: IDX_W] > IDX_W'(MAX_COLS)) ?
                 IDX_W'(MAX_COLS) : COLS_POR_FILA[r*IDX_W +: IDX_W];
      end
    end
  end

  always_comb begin
    sel_temp = sel_vec;
    for (int unsigned r = 0; r < NUM_FILAS; r++)
      if (where_fila == IDX_W'(r + 1) && !ES_ACCION[r])
        sel_temp[r*IDX_W +: IDX_W] = where_columna;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      where_fila    <= UNO;
      where_columna <= UNO;
      sel_vec       <= SEL_INICIAL;
      accion_pulso  <= '0;
      elige_q       <= 1'b0;
      elige_prev    <= 1'b0;
    end else begin
      elige_q      <= boton_elige;
      elige_prev   <= elige_q;
      accion_pulso <= '0;
      if (paso_dir[0]) begin
        if (where_columna > UNO) where_columna <= where_columna - UNO;
        else                     where_columna <= WRAP ? limite : UNO;
      end else if (paso_dir[1]) begin
        if (where_columna < limite) where_columna <= where_columna + UNO;
        else                        where_columna <= WRAP ? UNO : limite;
      end else if (paso_dir[2]) begin
        if (where_fila > UNO) where_fila <= where_fila - UNO;
        where_columna <= UNO;
      end else if (paso_dir[3]) begin
        if (where_fila < IDX_W'(NUM_FILAS)) where_fila <= where_fila + UNO;
        where_columna <= UNO;
      end else if (flancos[4]) begin
        for (int unsigned r = 0; r < NUM_FILAS; r++) begin
          if (where_fila == IDX_W'(r + 1)) begin
            if (ES_ACCION[r]) accion_pulso[r] <= 1'b1;
            else              sel_vec[r*IDX_W +: IDX_W] <= where_columna;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_menu_navegador_param.sv
// Directed bench for menu_navegador_param: a saturating and a wrapping
// instance share stimulus and are checked every cycle against a menu model.
module tb_menu_navegador_param;
  import menu_pkg::*;

  localparam int IW   = 3;
  localparam int NF   = 6;
  localparam int HOLD = 10;
  localparam int REP  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] btn = '0;  // 0 arriba, 1 abajo, 2 izq, 3 der, 4 elige

  logic [IW-1:0]    fila_o[2];
  logic [IW-1:0]    col_o[2];
  logic [NF*IW-1:0] sel_o[2];
  logic [NF*IW-1:0] temp_o[2];
  logic [NF-1:0]    pulso_o[2];

  int vectors = 0;
  int miscompares = 0;

  menu_navegador_param #(.WRAP(1'b0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_sat (
    .clk(clk), .reset(rst),
    .boton_arriba(btn[0]), .boton_abajo(btn[1]), .boton_izq(btn[2]),
    .boton_der(btn[3]), .boton_elige(btn[4]),
    .where_fila(fila_o[0]), .where_columna(col_o[0]), .sel_vec(sel_o[0]),
    .sel_temp(temp_o[0]), .accion_pulso(pulso_o[0]));

  menu_navegador_param #(.WRAP(1'b1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(REP)) dut_wrap (
    .clk(clk), .reset(rst),
    .boton_arriba(btn[0]), .boton_abajo(btn[1]), .boton_izq(btn[2]),
    .boton_der(btn[3]), .boton_elige(btn[4]),
    .where_fila(fila_o[1]), .where_columna(col_o[1]), .sel_vec(sel_o[1]),
    .sel_temp(temp_o[1]), .accion_pulso(pulso_o[1]));

  initial forever #5 clk = ~clk;

  // Menu layout, rows 1..6
  int cols_fila[1:NF] = '{1, 1, 1, 2, 6, 3};
  bit es_acc[1:NF]    = '{1, 1, 1, 0, 0, 0};
  int sel_rst[1:NF]   = '{1, 1, 1, 1, 1, 2};

  int m_fila[2];
  int m_col[2];
  int m_sel[2][1:NF];
  int m_pulso[2];
  bit s_cur[5];
  bit s_prev[5];
  int edad[4];

  function automatic void chk(input string nombre, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nombre, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_fila[i] = 1; m_col[i] = 1; m_pulso[i] = 0;
      for (int r = 1; r <= NF; r++) m_sel[i][r] = es_acc[r] ? 1 : sel_rst[r];
    end
    for (int b = 0; b < 5; b++) begin s_cur[b] = 0; s_prev[b] = 0; end
    for (int b = 0; b < 4; b++) edad[b] = 0;
  endfunction

  function automatic void model_apply(input int i, input int act, input bit wrap);
    int lim;
    lim = cols_fila[m_fila[i]];
    m_pulso[i] = 0;
    case (act)
      0: m_col[i] = (m_col[i] > 1) ? m_col[i] - 1 : (wrap ? lim : 1);
      1: m_col[i] = (m_col[i] < lim) ? m_col[i] + 1 : (wrap ? 1 : lim);
      2: begin m_fila[i] = (m_fila[i] > 1) ? m_fila[i] - 1 : 1; m_col[i] = 1; end
      3: begin m_fila[i] = (m_fila[i] < NF) ? m_fila[i] + 1 : NF; m_col[i] = 1; end
      4: if (es_acc[m_fila[i]]) m_pulso[i] = 1 << (m_fila[i] - 1);
         else m_sel[i][m_fila[i]] = m_col[i];
      default: ;
    endcase
  endfunction

  // A held direction steps on its edge, then HOLD+1 cycles later, then every REP.
  function automatic void model_step();
    bit rise[5];
    bit paso[5];
    int nrise;
    int act;
    nrise = 0;
    for (int b = 0; b < 5; b++) begin
      rise[b] = s_cur[b] && !s_prev[b];
      if (rise[b]) nrise++;
    end
    for (int b = 0; b < 4; b++)
      paso[b] = rise[b] || (s_cur[b] && nrise == 0 && edad[b] > HOLD && (edad[b] - HOLD - 1) % REP == 0);
    paso[4] = rise[4];
    act = -1;
    for (int b = 0; b < 5; b++) if (paso[b] && act < 0) act = b;
    model_apply(0, act, 1'b0);
    model_apply(1, act, 1'b1);
    for (int b = 0; b < 4; b++) edad[b] = (s_cur[b] && nrise > 0) ? 1 : edad[b] + 1;
    for (int b = 0; b < 5; b++) begin s_prev[b] = s_cur[b]; s_cur[b] = btn[b]; end
  endfunction

  initial begin
    model_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) model_reset();
      else model_step();
    end
  end

  logic [NF*IW-1:0] e_sel;
  logic [NF*IW-1:0] e_tmp;

  initial forever begin
    @(posedge clk);
    #2;
    for (int i = 0; i < 2; i++) begin
      for (int r = 1; r <= NF; r++) begin
        e_sel[(r-1)*IW +: IW] = IW'(m_sel[i][r]);
        e_tmp[(r-1)*IW +: IW] = (r == m_fila[i] && !es_acc[r]) ? IW'(m_col[i]) : IW'(m_sel[i][r]);
      end
      chk($sformatf("dut%0d where_fila", i),    32'(fila_o[i]),  32'(m_fila[i]));
      chk($sformatf("dut%0d where_columna", i), 32'(col_o[i]),   32'(m_col[i]));
      chk($sformatf("dut%0d sel_vec", i),       32'(sel_o[i]),   32'(e_sel));
      chk($sformatf("dut%0d sel_temp", i),      32'(temp_o[i]),  32'(e_tmp));
      chk($sformatf("dut%0d accion_pulso", i),  32'(pulso_o[i]), 32'(m_pulso[i]));
    end
  end

  task automatic pulsa(input int b);
    @(negedge clk); btn[b] = 1'b1;
    @(negedge clk); btn[b] = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  localparam logic [17:0] SEL_RST_LIT = 18'b010_001_001_001_001_001;

  task automatic chk_reset_lit(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s dut%0d fila", tag, i),  32'(fila_o[i]),  32'd1);
      chk($sformatf("%s dut%0d col", tag, i),   32'(col_o[i]),   32'd1);
      chk($sformatf("%s dut%0d sel", tag, i),   32'(sel_o[i]),   32'(SEL_RST_LIT));
      chk($sformatf("%s dut%0d temp", tag, i),  32'(temp_o[i]),  32'(SEL_RST_LIT));
      chk($sformatf("%s dut%0d pulso", tag, i), 32'(pulso_o[i]), 32'd0);
    end
  endtask

  int exp_sat[7]  = '{2, 3, 4, 5, 6, 6, 6};
  int exp_wrap[7] = '{2, 3, 4, 5, 6, 1, 2};
  int rec0[1:32];
  int rec1[1:32];
  int idx_t[8] = '{2, 12, 13, 16, 17, 21, 25, 30};
  int val_t[8] = '{2, 2, 3, 3, 4, 5, 6, 6};
  int npulsos;
  int nmal;
  bit visto;

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_lit("in reset");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_lit("after reset");

    for (int k = 1; k <= 7; k++) begin
      pulsa(3);
      chk($sformatf("der #%0d fila", k), 32'(fila_o[0]), 32'((k + 1 > 6) ? 6 : k + 1));
      chk($sformatf("der #%0d col", k),  32'(col_o[0]),  32'd1);
    end

    pulsa(2);
    chk("izq to color fila", 32'(fila_o[0]), 32'(FILA_COLOR));
    for (int k = 0; k < 7; k++) begin
      pulsa(1);
      chk($sformatf("abajo sat #%0d", k + 1),  32'(col_o[0]), 32'(exp_sat[k]));
      chk($sformatf("abajo wrap #%0d", k + 1), 32'(col_o[1]), 32'(exp_wrap[k]));
    end

    pulsa(2);
    pulsa(3);
    repeat (3) pulsa(1);
    chk("col before elige", 32'(col_o[0]), 32'd4);
    pulsa(4);
    chk("sel_vec row5 committed", 32'(sel_o[0]), 32'(18'b010_100_001_001_001_001));
    chk("sel_vec row5 wrap", 32'(sel_o[1][14:12]), 32'd4);
    pulsa(2);
    chk("sel_temp row5 kept", 32'(temp_o[0][14:12]), 32'd4);
    chk("sel_temp row4 live", 32'(temp_o[0][11:9]), 32'd1);

    pulsa(2);
    pulsa(2);
    chk("at guardar", 32'(fila_o[0]), 32'(FILA_GUARDAR));
    @(negedge clk); btn[4] = 1'b1;
    npulsos = 0; nmal = 0;
    repeat (100) begin
      @(posedge clk); #2;
      if (pulso_o[0] == 6'b000010) npulsos++;
      else if (pulso_o[0] != 6'b0) nmal++;
    end
    @(negedge clk); btn[4] = 1'b0;
    repeat (2) @(negedge clk);
    chk("held elige pulse count", 32'(npulsos), 32'd1);
    chk("held elige stray pulses", 32'(nmal), 32'd0);

    repeat (3) pulsa(3);
    @(negedge clk); btn[1] = 1'b1;
    for (int c = 1; c <= 32; c++) begin
      @(posedge clk); #2;
      rec0[c] = 32'(col_o[0]);
      rec1[c] = 32'(col_o[1]);
      if (c == 30) begin @(negedge clk); btn[1] = 1'b0; end
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("repeat col at c%0d", idx_t[k]), 32'(rec0[idx_t[k]]), 32'(val_t[k]));
    chk("repeat wrap col c28", 32'(rec1[28]), 32'd6);
    chk("repeat wrap col c29", 32'(rec1[29]), 32'd1);

    pulsa(3);
    repeat (2) pulsa(1);
    @(negedge clk); btn[0] = 1'b1; btn[3] = 1'b1;
    @(negedge clk); btn[0] = 1'b0; btn[3] = 1'b0;
    repeat (2) @(negedge clk);
    chk("arriba+der fila", 32'(fila_o[0]), 32'(FILA_ESCALA));
    chk("arriba+der col",  32'(col_o[0]),  32'd2);
    chk("arriba+der col wrap", 32'(col_o[1]), 32'd2);

    pulsa(2);
    @(negedge clk); btn[1] = 1'b1;
    repeat (18) @(posedge clk);
    #2 chk("mid-repeat col", 32'(col_o[0]), 32'd4);
    #1 rst = 1'b1; btn[1] = 1'b0;
    #1 chk_reset_lit("reset mid-repeat");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    @(negedge clk); btn[4] = 1'b1;
    visto = 1'b0;
    for (int k = 0; k < 8 && !visto; k++) begin
      @(posedge clk); #2;
      if (pulso_o[0] != 6'b0) visto = 1'b1;
    end
    chk("nuevo pulse seen", 32'(visto), 32'd1);
    chk("nuevo pulse value", 32'(pulso_o[0]), 32'(6'b000001));
    #1 rst = 1'b1;
    #1 chk("pulse dropped by reset", 32'(pulso_o[0]), 32'd0);
    btn[4] = 1'b0;
    btn[3] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("der held through reset", 32'(fila_o[0]), 32'd2);
    btn[3] = 1'b0;
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
